// File: rtl/sda_kernel_ctrl_axi_bridge.sv
// ---------------------------------------------------------------------------
// sda_kernel_ctrl_axi_bridge
//
// Bridges a single-outstanding AXI4-Lite slave port onto a simple
// request/acknowledge register bus. One transaction is in flight at a time;
// simultaneous read and write requests are served round-robin (write first
// after reset).
//
// Optional feature (macro SDA_KERNEL_CTRL_TIMEOUT_EN):
//   When defined, a 16-bit counter bounds the register-bus wait. After
//   TimeoutCycles cycles without regAck, the transaction completes with
//   SLVERR (and rdata = 0 for reads). When undefined, requests wait forever
//   and every response is OKAY.
//
// Parameters:
//   RegAddrWidth  - width of awaddr/araddr/regAddr
//   TimeoutCycles - ack timeout in cycles (2..65535), used with the macro
//
// Ports:
//   clk, rstn                          - clock, async active-low reset
//   awvalid/awready/awaddr             - AXI write address channel
//   wvalid/wready/wdata/wstrb          - AXI write data channel
//   bvalid/bready/bresp                - AXI write response channel
//   arvalid/arready/araddr             - AXI read address channel
//   rvalid/rready/rdata/rresp          - AXI read data channel
//   regReq/regAck                      - register-bus handshake
//   regWriteEn/regAddr/regWData/regWStrb - request qualifiers (stable while regReq)
//   regRData                           - read data, sampled in the regAck cycle
// ---------------------------------------------------------------------------
module sda_kernel_ctrl_axi_bridge #(
  parameter int unsigned RegAddrWidth  = 12,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                    clk,
  input  logic                    rstn,
  // AXI4-Lite write address
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [RegAddrWidth-1:0] awaddr,
  // AXI4-Lite write data
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [31:0]             wdata,
  input  logic [3:0]              wstrb,
  // AXI4-Lite write response
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  // AXI4-Lite read address
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [RegAddrWidth-1:0] araddr,
  // AXI4-Lite read data
  output logic                    rvalid,
  input  logic                    rready,
  output logic [31:0]             rdata,
  output logic [1:0]              rresp,
  // Register bus
  output logic                    regReq,
  input  logic                    regAck,
  output logic                    regWriteEn,
  output logic [RegAddrWidth-1:0] regAddr,
  output logic [31:0]             regWData,
  output logic [3:0]              regWStrb,
  input  logic [31:0]             regRData
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    WR_RESP,
    RD_RESP
  } state_t;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  // Only 2..65535 fit the 16-bit timeout counter; this block marks an
  // unsupported value in the elaborated hierarchy.
  if (TimeoutCycles < 2 || TimeoutCycles > 65535) begin : g_timeout_out_of_range
  end

`ifdef SDA_KERNEL_CTRL_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);
  logic [15:0] tmo_cnt;
`endif

  state_t     state;
  logic       last_read;  // 1 = the most recently served transaction was a read
  logic [1:0] resp;

  logic wr_elig;
  logic rd_elig;
  logic pick_wr;
  logic pick_rd;

  // Round-robin: on a tie the type that was not served last wins.
  always_comb begin
    wr_elig = awvalid & wvalid;
    rd_elig = arvalid;
    pick_wr = wr_elig & (~rd_elig | last_read);
    pick_rd = rd_elig & (~wr_elig | ~last_read);
  end

  assign bresp = resp;
  assign rresp = resp;

  // IDLE first raises the ready(s) for one cycle; the handshake completes on
  // the following edge, which is the accept cycle. Together with one RESP
  // cycle this keeps regReq low for at least two cycles between requests.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      last_read  <= 1'b1;
      resp       <= RespOkay;
      awready    <= 1'b0;
      wready     <= 1'b0;
      arready    <= 1'b0;
      bvalid     <= 1'b0;
      rvalid     <= 1'b0;
      rdata      <= '0;
      regReq     <= 1'b0;
      regWriteEn <= 1'b0;
      regAddr    <= '0;
      regWData   <= '0;
      regWStrb   <= '0;
`ifdef SDA_KERNEL_CTRL_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (awready) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            if (awvalid && wvalid) begin
              regReq     <= 1'b1;
              regWriteEn <= 1'b1;
              regAddr    <= awaddr;
              regWData   <= wdata;
              regWStrb   <= wstrb;
              last_read  <= 1'b0;
              state      <= WR_REQ;
`ifdef SDA_KERNEL_CTRL_TIMEOUT_EN
              tmo_cnt    <= '0;
`endif
            end
          end else if (arready) begin
            arready <= 1'b0;
            if (arvalid) begin
              regReq     <= 1'b1;
              regWriteEn <= 1'b0;
              regAddr    <= araddr;
              regWData   <= '0;
              regWStrb   <= '0;
              last_read  <= 1'b1;
              state      <= RD_REQ;
`ifdef SDA_KERNEL_CTRL_TIMEOUT_EN
              tmo_cnt    <= '0;
`endif
            end
          end else if (pick_wr) begin
            awready <= 1'b1;
            wready  <= 1'b1;
          end else if (pick_rd) begin
            arready <= 1'b1;
          end
        end

        WR_REQ, RD_REQ: begin
          if (regAck) begin
            regReq <= 1'b0;
            resp   <= RespOkay;
            if (state == RD_REQ) begin
              rdata  <= regRData;
              rvalid <= 1'b1;
              state  <= RD_RESP;
            end else begin
              bvalid <= 1'b1;
              state  <= WR_RESP;
            end
          end
`ifdef SDA_KERNEL_CTRL_TIMEOUT_EN
          else if (tmo_cnt == TimeoutLast) begin
            regReq <= 1'b0;
            resp   <= RespSlverr;
            if (state == RD_REQ) begin
              rdata  <= '0;
              rvalid <= 1'b1;
              state  <= RD_RESP;
            end else begin
              bvalid <= 1'b1;
              state  <= WR_RESP;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end

        WR_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end

        RD_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
